sap_control_sequencer: RTL and testbench

Sequential controller for the SAP CPU: a one-hot T-state ring counter plus opcode decoder that drives the full control word for every microstep of fetch and execute. It sits between the instruction register (opcode field in) and the datapath (PC, MAR, RAM, IR, accumulator, B register, ALU, output register). It adds four things:
- parametrised opcode width and opcode values;
- an optional short-cycle mode;
- a run/pause gate;
- a latched halt state.

---
 rtl/sap_control_sequencer.sv | 116 +++++++++++
 tb/tb_sap_control_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// SAP CPU control sequencer: one-hot T-state ring with opcode decode driving
// the datapath control word, plus run/pause gating and a latched halt state.
module sap_control_sequencer #(
  parameter int                   OPCODE_W    = 4,
  parameter logic [OPCODE_W-1:0]  OP_LDA      = OPCODE_W'(0),
  parameter logic [OPCODE_W-1:0]  OP_ADD      = OPCODE_W'(1),
  parameter logic [OPCODE_W-1:0]  OP_SUB      = OPCODE_W'(2),
  parameter logic [OPCODE_W-1:0]  OP_OUT      = OPCODE_W'(14),
  parameter logic [OPCODE_W-1:0]  OP_HLT      = OPCODE_W'(15),
  parameter bit                   SHORT_CYCLE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] instruction,
  output logic [5:0]          t_state,
  output logic                cp,
  output logic                ep,
  output logic                lm,
  output logic                ce,
  output logic                li,
  output logic                ei,
  output logic                la,
  output logic                ea,
  output logic                su,
  output logic                eu,
  output logic                lb,
  output logic                lo,
  output logic                hlt_n
);

  typedef enum logic [5:0] {
    S_HALT = 6'b000000,
    S_T1   = 6'b000001,
    S_T2   = 6'b000010,
    S_T3   = 6'b000100,
    S_T4   = 6'b001000,
    S_T5   = 6'b010000,
    S_T6   = 6'b100000
  } state_t;

  state_t state;
  logic   halted;
  logic   is_hlt, is_lda, is_add, is_sub, is_out;

  // Priority decode so that colliding opcode parameters resolve HLT > LDA > ADD > SUB > OUT
  always_comb begin
    is_hlt = (instruction == OP_HLT);
    is_lda = !is_hlt && (instruction == OP_LDA);
    is_add = !is_hlt && !is_lda && (instruction == OP_ADD);
    is_sub = !is_hlt && !is_lda && !is_add && (instruction == OP_SUB);
    is_out = !is_hlt && !is_lda && !is_add && !is_sub && (instruction == OP_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_T1;
    end else if (run) begin
      case (state)
        S_HALT: state <= S_HALT;
        S_T1:   state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3:   state <= S_T4;
        S_T4: begin
          if (is_hlt)
            state <= S_HALT;
          else if (SHORT_CYCLE && !is_lda && !is_add && !is_sub)
            state <= S_T1;
          else
            state <= S_T5;
        end
        S_T5:   state <= (SHORT_CYCLE && is_lda) ? S_T1 : S_T6;
        S_T6:   state <= S_T1;
        default: state <= S_T1;
      endcase
    end
  end

  assign halted  = (state == S_HALT);
  assign t_state = state;

  always_comb begin
    cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0;
    li = 1'b0; ei = 1'b0; la = 1'b0; ea = 1'b0;
    su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;
    hlt_n = !(halted || (state == S_T4 && is_hlt));
    if (run && !halted) begin
      case (state)
        S_T1: begin ep = 1'b1; lm = 1'b1; end
        S_T2: cp = 1'b1;
        S_T3: begin ce = 1'b1; li = 1'b1; end
        S_T4: begin
          if (is_lda || is_add || is_sub) begin
            ei = 1'b1; lm = 1'b1;
          end else if (is_out) begin
            ea = 1'b1; lo = 1'b1;
          end
        end
        S_T5: begin
          if (is_lda) begin
            ce = 1'b1; la = 1'b1;
          end else if (is_add || is_sub) begin
            ce = 1'b1; lb = 1'b1;
          end
        end
        S_T6: begin
          if (is_add || is_sub) begin
            eu = 1'b1; la = 1'b1; su = is_sub;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: one instance in full-cycle mode,
// one in short-cycle mode, driven by directed per-cycle expectations.
module tb_sap_control_sequencer;

  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  localparam logic [3:0] I_LDA = 4'b0000, I_ADD = 4'b0001, I_SUB = 4'b0010;
  localparam logic [3:0] I_OUT = 4'b1110, I_HLT = 4'b1111, I_NOP = 4'b0101;

  logic clk;
  logic rst0_n, run0, rst1_n, run1;
  logic [3:0] ins0, ins1;
  logic [5:0] t0, t1;
  logic cp0, ep0, lm0, ce0, li0, ei0, la0, ea0, su0, eu0, lb0, lo0, h0;
  logic cp1, ep1, lm1, ce1, li1, ei1, la1, ea1, su1, eu1, lb1, lo1, h1;

  sap_control_sequencer #(.SHORT_CYCLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .run(run0), .instruction(ins0), .t_state(t0),
    .cp(cp0), .ep(ep0), .lm(lm0), .ce(ce0), .li(li0), .ei(ei0), .la(la0),
    .ea(ea0), .su(su0), .eu(eu0), .lb(lb0), .lo(lo0), .hlt_n(h0));

  sap_control_sequencer #(.SHORT_CYCLE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .run(run1), .instruction(ins1), .t_state(t1),
    .cp(cp1), .ep(ep1), .lm(lm1), .ce(ce1), .li(li1), .ei(ei1), .la(la1),
    .ea(ea1), .su(su1), .eu(eu1), .lb(lb1), .lo(lo1), .hlt_n(h1));

  typedef struct {
    int          dut;
    logic [5:0]  t;
    logic [11:0] c;
    logic        h;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compares one expectation per cycle, away from the rising edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [5:0]  at;
      logic [11:0] ac;
      logic        ah;
      e = sb.pop_front();
      if (e.dut == 0) begin
        at = t0; ah = h0;
        ac = {cp0, ep0, lm0, ce0, li0, ei0, la0, ea0, su0, eu0, lb0, lo0};
      end else begin
        at = t1; ah = h1;
        ac = {cp1, ep1, lm1, ce1, li1, ei1, la1, ea1, su1, eu1, lb1, lo1};
      end
      n_chk++;
      if (at !== e.t || ac !== e.c || ah !== e.h) begin
        n_fail++;
        $display("FAIL %s dut%0d: got t=%b c=%b h=%b, expected t=%b c=%b h=%b",
                 e.name, e.dut, at, ac, ah, e.t, e.c, e.h);
      end
    end
  end

  task automatic chk(input int d, input logic [5:0] t, input logic [11:0] c,
                     input logic h, input string nm);
    exp_t e;
    e.dut = d; e.t = t; e.c = c; e.h = h; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int d, input string nm);
    chk(d, 6'h01, EP | LM, 1'b1, {nm, "_t1"});
    chk(d, 6'h02, CP,      1'b1, {nm, "_t2"});
    chk(d, 6'h04, CE | LI, 1'b1, {nm, "_t3"});
  endtask

  initial begin
    rst0_n = 1'b0; run0 = 1'b1; ins0 = I_LDA;
    rst1_n = 1'b0; run1 = 1'b1; ins1 = I_OUT;
    @(posedge clk);
    #1;
    chk(0, 6'h01, EP | LM, 1'b1, "reset_state");
    rst0_n = 1'b1;

    // Full-cycle LDA
    fetch(0, "lda");
    chk(0, 6'h08, EI | LM, 1'b1, "lda_t4");
    chk(0, 6'h10, CE | LA, 1'b1, "lda_t5");
    chk(0, 6'h20, NONE,    1'b1, "lda_t6");

    ins0 = I_SUB;
    fetch(0, "sub");
    chk(0, 6'h08, EI | LM,      1'b1, "sub_t4");
    chk(0, 6'h10, CE | LB,      1'b1, "sub_t5");
    chk(0, 6'h20, EU | SU | LA, 1'b1, "sub_t6");

    ins0 = I_ADD;
    fetch(0, "add");
    chk(0, 6'h08, EI | LM, 1'b1, "add_t4");
    chk(0, 6'h10, CE | LB, 1'b1, "add_t5");
    chk(0, 6'h20, EU | LA, 1'b1, "add_t6");

    // Pause in T2
    ins0 = I_LDA;
    chk(0, 6'h01, EP | LM, 1'b1, "pause_t1");
    run0 = 1'b0;
    for (int i = 0; i < 3; i++) chk(0, 6'h02, NONE, 1'b1, "pause_hold");
    run0 = 1'b1;
    chk(0, 6'h02, CP,      1'b1, "pause_resume_t2");
    chk(0, 6'h04, CE | LI, 1'b1, "pause_t3");
    chk(0, 6'h08, EI | LM, 1'b1, "pause_t4");
    chk(0, 6'h10, CE | LA, 1'b1, "pause_t5");
    chk(0, 6'h20, NONE,    1'b1, "pause_t6");

    // Undefined opcode behaves as NOP
    ins0 = I_NOP;
    fetch(0, "nop");
    chk(0, 6'h08, NONE, 1'b1, "nop_t4");
    chk(0, 6'h10, NONE, 1'b1, "nop_t5");
    chk(0, 6'h20, NONE, 1'b1, "nop_t6");

    // Asynchronous reset in T5 of ADD
    ins0 = I_ADD;
    fetch(0, "add2");
    chk(0, 6'h08, EI | LM, 1'b1, "add2_t4");
    #1;
    rst0_n = 1'b0;
    chk(0, 6'h01, EP | LM, 1'b1, "async_reset_t5");
    rst0_n = 1'b1;
    chk(0, 6'h01, EP | LM, 1'b1, "reset_release_t1");
    chk(0, 6'h02, CP,      1'b1, "reset_release_t2");
    chk(0, 6'h04, CE | LI, 1'b1, "reset_release_t3");
    chk(0, 6'h08, EI | LM, 1'b1, "reset_release_t4");
    chk(0, 6'h10, CE | LB, 1'b1, "reset_release_t5");
    chk(0, 6'h20, EU | LA, 1'b1, "reset_release_t6");

    // Halt
    ins0 = I_HLT;
    fetch(0, "hlt");
    chk(0, 6'h08, NONE, 1'b0, "hlt_t4");
    chk(0, 6'h00, NONE, 1'b0, "halted");
    for (int i = 0; i < 20; i++) begin
      run0 = i[0];
      ins0 = 4'(i * 7);
      chk(0, 6'h00, NONE, 1'b0, "halt_hold");
    end
    run0 = 1'b1;
    ins0 = I_LDA;
    #1;
    rst0_n = 1'b0;
    chk(0, 6'h01, EP | LM, 1'b1, "halt_reset");
    rst0_n = 1'b1;
    chk(0, 6'h01, EP | LM, 1'b1, "halt_reset_t1");
    chk(0, 6'h02, CP,      1'b1, "halt_reset_t2");

    // Short-cycle instance: OUT (4), LDA (5), ADD (6), then HLT
    rst1_n = 1'b1;
    fetch(1, "sc_out");
    chk(1, 6'h08, EA | LO, 1'b1, "sc_out_t4");
    ins1 = I_LDA;
    fetch(1, "sc_lda");
    chk(1, 6'h08, EI | LM, 1'b1, "sc_lda_t4");
    chk(1, 6'h10, CE | LA, 1'b1, "sc_lda_t5");
    ins1 = I_ADD;
    fetch(1, "sc_add");
    chk(1, 6'h08, EI | LM, 1'b1, "sc_add_t4");
    chk(1, 6'h10, CE | LB, 1'b1, "sc_add_t5");
    chk(1, 6'h20, EU | LA, 1'b1, "sc_add_t6");
    ins1 = I_NOP;
    fetch(1, "sc_nop");
    chk(1, 6'h08, NONE, 1'b1, "sc_nop_t4");
    ins1 = I_HLT;
    fetch(1, "sc_hlt");
    chk(1, 6'h08, NONE, 1'b0, "sc_hlt_t4");
    chk(1, 6'h00, NONE, 1'b0, "sc_halted");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
